// File: rtl/intel_avalon_pkg.sv
// Shared Avalon-MM definitions for the slave RAM: bus request/response structs,
// response codes, responder FSM states and a burst-length helper.
package intel_avalon_pkg;

    localparam int unsigned AVALON_ADDR_WIDTH     = 32;
    localparam int unsigned AVALON_DATA_WIDTH     = 32;
    localparam int unsigned AVALON_BURST_WIDTH    = 8;
    localparam int unsigned AVALON_BYTES_PER_WORD = AVALON_DATA_WIDTH / 8;
    localparam int unsigned AVALON_BYTE_SHIFT     = $clog2(AVALON_BYTES_PER_WORD);

    typedef enum logic [1:0] {
        AVALON_OKAY   = 2'b00,
        AVALON_EXOKAY = 2'b01,
        AVALON_SLVERR = 2'b10,
        AVALON_DECERR = 2'b11
    } avalon_resp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        WR_RESP  = 2'd3
    } avalon_slv_st_t;

    typedef struct packed {
        logic [AVALON_ADDR_WIDTH-1:0]     address;
        logic [AVALON_BYTES_PER_WORD-1:0] byte_enable;
        logic                             read;
        logic                             write;
        logic [AVALON_DATA_WIDTH-1:0]     write_data;
        logic [AVALON_BURST_WIDTH-1:0]    burst_count;
        logic                             begin_burst_transfer;
        logic                             lock;
        logic                             debug_access;
    } s_avalon_mosi_t;

    typedef struct packed {
        logic [AVALON_DATA_WIDTH-1:0] read_data;
        avalon_resp_t                 response;
        logic                         wait_request;
        logic                         read_data_valid;
        avalon_resp_t                 write_response_valid;
    } s_avalon_miso_t;

    // A burst count of zero means a single beat.
    function automatic logic [AVALON_BURST_WIDTH-1:0] burst_len(
        input logic [AVALON_BURST_WIDTH-1:0] bc
    );
        return (bc == '0) ? AVALON_BURST_WIDTH'(1) : bc;
    endfunction

endpackage

// File: rtl/avalon_sp_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port (one cycle of read latency). Contents are never reset.
module avalon_sp_ram
    import intel_avalon_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = AVALON_DATA_WIDTH
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [WORDS];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < DW/8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_mm_slave_ram.sv
// Avalon-MM burst-capable slave wrapping a single-port RAM.
// Define AVALON_WRITE_RESP_EN to add a one-cycle write response after each write burst.
module avalon_mm_slave_ram
    import intel_avalon_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic           aclk,
    input  logic           arst,
    input  s_avalon_mosi_t mosi,
    output s_avalon_miso_t miso
);

    localparam int unsigned RAW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef logic [AVALON_ADDR_WIDTH-1:0]  addr_t;
    typedef logic [AVALON_BURST_WIDTH-1:0] cnt_t;

    avalon_slv_st_t               state_q;
    addr_t                        idx_q;
    cnt_t                         left_q;
    logic                         rvalid_q;
    logic                         roor_q;
    avalon_resp_t                 resp_q;
    logic                         busy_q;
`ifdef AVALON_WRITE_RESP_EN
    logic                         err_q;
    logic                         wresp_q;
`endif

    addr_t                        cmd_idx;
    addr_t                        beat_idx;
    cnt_t                         len;
    logic                         beat_oor;
    logic                         rd_cmd;
    logic                         wr_cmd;
    logic                         wr_beat;
    logic                         ram_we;
    logic [RAW-1:0]               ram_addr;
    logic [AVALON_DATA_WIDTH-1:0] ram_rdata;
    logic                         unused_sideband;

    // The RAM address is the current beat: the command word while idle, otherwise
    // the running beat counter, so a read's data lands one cycle after its beat.
    always_comb begin
        cmd_idx         = (mosi.address - addr_t'(BASE_ADDR)) >> AVALON_BYTE_SHIFT;
        len             = burst_len(mosi.burst_count);
        rd_cmd          = (state_q == IDLE) && !arst && mosi.read;
        wr_cmd          = (state_q == IDLE) && !arst && mosi.write && !mosi.read;
        wr_beat         = (state_q == WR_BURST) && !arst && mosi.write;
        beat_idx        = (state_q == IDLE) ? cmd_idx : idx_q;
        beat_oor        = (beat_idx >= addr_t'(MEM_WORDS));
        ram_we          = (wr_cmd || wr_beat) && !beat_oor;
        ram_addr        = beat_idx[RAW-1:0];
        unused_sideband = ^{mosi.lock, mosi.debug_access, mosi.begin_burst_transfer};
    end

    avalon_sp_ram #(
        .WORDS(MEM_WORDS),
        .AW   (RAW),
        .DW   (AVALON_DATA_WIDTH)
    ) u_ram (
        .clk_i  (aclk),
        .we_i   (ram_we),
        .be_i   (mosi.byte_enable),
        .addr_i (ram_addr),
        .wdata_i(mosi.write_data),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            left_q   <= '0;
            rvalid_q <= 1'b0;
            roor_q   <= 1'b0;
            resp_q   <= AVALON_OKAY;
            busy_q   <= 1'b0;
`ifdef AVALON_WRITE_RESP_EN
            err_q    <= 1'b0;
            wresp_q  <= 1'b0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            roor_q   <= 1'b0;
            resp_q   <= AVALON_OKAY;
`ifdef AVALON_WRITE_RESP_EN
            wresp_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rd_cmd) begin
                        state_q  <= RD_BURST;
                        busy_q   <= 1'b1;
                        rvalid_q <= 1'b1;
                        roor_q   <= beat_oor;
                        resp_q   <= beat_oor ? AVALON_DECERR : AVALON_OKAY;
                        idx_q    <= beat_idx + addr_t'(1);
                        left_q   <= len - cnt_t'(1);
                    end else if (wr_cmd) begin
                        idx_q  <= beat_idx + addr_t'(1);
                        left_q <= len - cnt_t'(1);
                        if (len != cnt_t'(1)) begin
                            state_q <= WR_BURST;
                        end
`ifdef AVALON_WRITE_RESP_EN
                        err_q <= beat_oor;
                        if (len == cnt_t'(1)) begin
                            state_q <= WR_RESP;
                            busy_q  <= 1'b1;
                            wresp_q <= 1'b1;
                            resp_q  <= beat_oor ? AVALON_DECERR : AVALON_OKAY;
                        end
`endif
                    end
                end
                RD_BURST: begin
                    if (left_q != '0) begin
                        rvalid_q <= 1'b1;
                        roor_q   <= beat_oor;
                        resp_q   <= beat_oor ? AVALON_DECERR : AVALON_OKAY;
                        idx_q    <= idx_q + addr_t'(1);
                        left_q   <= left_q - cnt_t'(1);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                WR_BURST: begin
                    if (wr_beat) begin
                        idx_q  <= idx_q + addr_t'(1);
                        left_q <= left_q - cnt_t'(1);
`ifdef AVALON_WRITE_RESP_EN
                        err_q  <= err_q | beat_oor;
                        if (left_q == cnt_t'(1)) begin
                            state_q <= WR_RESP;
                            busy_q  <= 1'b1;
                            wresp_q <= 1'b1;
                            resp_q  <= (err_q | beat_oor) ? AVALON_DECERR : AVALON_OKAY;
                        end
`else
                        if (left_q == cnt_t'(1)) begin
                            state_q <= IDLE;
                        end
`endif
                    end
                end
                WR_RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        miso                 = '0;
        miso.read_data       = (rvalid_q && !roor_q) ? ram_rdata : '0;
        miso.response        = resp_q;
        miso.wait_request    = arst | busy_q;
        miso.read_data_valid = rvalid_q;
`ifdef AVALON_WRITE_RESP_EN
        miso.write_response_valid = wresp_q ? AVALON_EXOKAY : AVALON_OKAY;
`else
        miso.write_response_valid = AVALON_OKAY;
`endif
    end

endmodule
